// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter: 8N1 frames, or 8E1 with FIFO_UART_TX_PARITY_EN.
// Pulls one byte per frame from a synchronous FIFO (1-cycle read latency).
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       r_en,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    WAIT   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY = 3'd5,
`endif
    STOP   = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          rel_q;
  logic          tx_q, tx_d;
  logic          r_en_q, r_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
`ifdef FIFO_UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
`ifdef FIFO_UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        // rel_q keeps the first edge after reset release read-free
        if (!rel_q && tx_en && !fifo_empty) state_d = READ;
      end
      READ: state_d = WAIT;
      WAIT: begin
        state_d = START;
        shreg_d = fifo_data;
        cnt_d   = LAST;
`ifdef FIFO_UART_TX_PARITY_EN
        par_d   = ^fifo_data;
`endif
      end
      START: begin
        if (cnt_q == '0) begin
          state_d = DATA;
          cnt_d   = LAST;
          idx_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          cnt_d   = LAST;
          shreg_d = shreg_q >> 1;
          if (idx_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (cnt_q == '0) begin
          state_d = STOP;
          cnt_d   = LAST;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`endif
      STOP: begin
        if (cnt_q == '0) state_d = IDLE;
        else cnt_d = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:  tx_d = 1'b0;
      DATA:   tx_d = shreg_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
    r_en_d = (state_d == READ);
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (cnt_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      rel_q   <= 1'b1;
      tx_q    <= 1'b1;
      r_en_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      rel_q   <= 1'b0;
      tx_q    <= tx_d;
      r_en_q  <= r_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign r_en    = r_en_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model plus frame-level reference of the line.
// Define FIFO_UART_TX_PARITY_EN for both files to check 8E1 frames.
module tb_fifo_uart_tx;

  localparam int C = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = C * NB;
  localparam int BLK   = FRAME + 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_en = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_data = '0;
  logic       r_en, tx, busy, tx_done;

  logic [7:0] mem [0:63];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic [7:0] exp_q [$];

  int checks = 0;
  int errors = 0;

  fifo_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst(rst), .tx_en(tx_en),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .r_en(r_en), .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (r_en && wr_ptr != rd_ptr) begin
      fifo_data <= mem[rd_ptr[5:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[5:0]] = b;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(b);
  endtask

  task automatic flush();
    wr_ptr = rd_ptr;
    exp_q.delete();
  endtask

  // Line level j cycles after the start bit begins, from the frame layout
  function automatic logic exp_tx(input logic [7:0] b, input int j);
    int n;
    n = j / C;
    if (n == 0) return 1'b0;
    if (n <= 8) return b[n-1];
    if (NB == 11 && n == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic wait_read(output bit ok);
    int w;
    w = 0;
    @(negedge clk);
    while (r_en !== 1'b1 && w < 60) begin
      @(negedge clk);
      w++;
    end
    checks++;
    ok = (r_en === 1'b1);
    if (!ok) begin
      errors++;
      $display("FAIL read_start: r_en=%b expected 1 within 60 cycles", r_en);
    end
  endtask

  task automatic check_idle(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if ({tx, r_en, busy, tx_done} !== 4'b1000) begin
        errors++;
        $display("FAIL %s cyc%0d: {tx,r_en,busy,done}=%b expected 1000",
                 name, i, {tx, r_en, busy, tx_done});
      end
    end
  endtask

  task automatic check_stream(input string name, input int nbytes,
                              input int drop_at, input int tail);
    bit ok;
    logic [7:0] b;
    logic [3:0] e;
    int cyc;
    wait_read(ok);
    if (!ok) return;
    cyc = 0;
    for (int n = 0; n < nbytes; n++) begin
      b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      for (int k = 0; k < BLK; k++) begin
        if (k == 0)          e = 4'b1110;
        else if (k == 1)     e = 4'b1010;
        else if (k < 2 + FRAME)
          e = {exp_tx(b, k - 2), 1'b0, 1'b1, (k - 2 == FRAME - 1)};
        else                 e = 4'b1000;
        if (cyc == drop_at) tx_en = 1'b0;
        checks++;
        if ({tx, r_en, busy, tx_done} !== e) begin
          errors++;
          $display("FAIL %s byte%0d(%h) k%0d: {tx,r_en,busy,done}=%b expected %b",
                   name, n, b, k, {tx, r_en, busy, tx_done}, e);
        end
        cyc++;
        @(negedge clk);
      end
    end
    for (int i = 0; i < tail; i++) begin
      checks++;
      if ({tx, r_en, busy, tx_done} !== 4'b1000) begin
        errors++;
        $display("FAIL %s tail%0d: {tx,r_en,busy,done}=%b expected 1000",
                 name, i, {tx, r_en, busy, tx_done});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({tx, r_en, busy, tx_done} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_state: {tx,r_en,busy,done}=%b expected 1000",
               {tx, r_en, busy, tx_done});
    end
    push(8'hA5);
    tx_en = 1'b1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (r_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_read: r_en=%b expected 0 after first edge", r_en);
    end
    check_stream("reset_first", 1, -1, 2);
    tx_en = 1'b0;
  endtask

  task automatic test_single();
    push(8'h11);
    tx_en = 1'b1;
    check_stream("single_11", 1, -1, 3);
    tx_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    push(8'h12);
    push(8'h13);
    push(8'h14);
    tx_en = 1'b1;
    check_stream("b2b", 3, -1, 4);
    tx_en = 1'b0;
  endtask

  task automatic test_parity_bytes();
    push(8'h11);
    push(8'h13);
    push(8'hFF);
    push(8'h80);
    tx_en = 1'b1;
    check_stream("parity", 4, -1, 3);
    tx_en = 1'b0;
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) push(8'($urandom));
      tx_en = 1'b1;
      check_stream("random", n, -1, 2);
      tx_en = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic test_flow();
    tx_en = 1'b0;
    push(8'h3C);
    push(8'hC3);
    check_idle("flow_disabled", 20);
    tx_en = 1'b1;
    check_stream("flow_drop", 1, 20, 25);
    flush();
  endtask

  task automatic test_empty();
    flush();
    tx_en = 1'b1;
    check_idle("empty", 30);
    tx_en = 1'b0;
  endtask

  task automatic test_reset_midframe();
    bit ok;
    push(8'h55);
    tx_en = 1'b1;
    wait_read(ok);
    repeat (14) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midframe_busy: busy=%b expected 1", busy);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({tx, r_en, busy, tx_done} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_midframe: {tx,r_en,busy,done}=%b expected 1000",
               {tx, r_en, busy, tx_done});
    end
    flush();
    tx_en = 1'b0;
    check_idle("reset_hold", 3);
    rst = 1'b0;
    check_idle("after_reset", 10);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_parity_bytes();
    test_random();
    test_flow();
    test_empty();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
